imem_loader: RTL and testbench

- Boot-time writer for the instruction memory; the core only ever reads that memory.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to the instruction memory write port and holds the core in reset until a frame loads with a good checksum.
- Sits between the host byte link and the instruction memory / core reset.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 186 ++++++++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// imem_loader_if : host byte stream plus instruction-memory write port.
// Rev 1.0
// ============================================================================
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Loader side: consumes the byte stream, drives the memory write port.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    // Host / memory side.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : framed byte-stream boot loader for the instruction memory.
// Optional macro IMEM_LOADER_TIMEOUT_EN adds a mid-frame idle timeout. Rev 1.0
// ============================================================================
module imem_loader #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    imem_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [ADDR_WIDTH:0] words_written
);

    localparam logic [7:0]  c_sync     = 8'hA5;
    localparam logic [16:0] c_capacity = 17'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_rdy_en;
    logic [15:0]         r_len;
    logic [7:0]          r_csum;
    logic [1:0]          r_lane;
    logic [23:0]         r_lanes;
    logic                w_accept;
    logic                w_timeout;
    logic                w_last_word;
    logic [ADDR_WIDTH:0] w_ww_next;
    logic [16:0]         w_len_full;

    // r_rdy_en keeps in_ready low while reset is asserted and opens it afterwards.
    assign bus.in_ready = r_rdy_en & ~bus.mem_we;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_len_full   = {1'b0, bus.in_data, r_len[7:0]};
    assign w_ww_next    = words_written + (ADDR_WIDTH + 1)'(1);
    assign w_last_word  = (32'(w_ww_next) == 32'(r_len));

    assign cpu_hold   = (r_state != S_DONE);
    assign load_done  = (r_state == S_DONE);
    assign load_error = (r_state == S_ERR);

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_idle_cnt;
    logic               w_running;

    assign w_running = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                       (r_state == S_DATA)   || (r_state == S_CSUM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= '0;
        end else if (!w_running || w_accept) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_cnt_w'(1);
        end
    end

    assign w_timeout = w_running && !w_accept &&
                       (r_idle_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));
`else
    // TIMEOUT_CYCLES only has an effect in the timeout build.
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_accept && (bus.in_data == c_sync)) begin
                    w_state_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    w_state_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if (w_len_full > c_capacity) begin
                        w_state_next = S_ERR;
                    end else if (w_len_full == 17'd0) begin
                        w_state_next = S_CSUM;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (bus.mem_we && w_last_word) begin
                    w_state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_next = (bus.in_data == r_csum) ? S_DONE : S_ERR;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy_en      <= 1'b0;
            r_len         <= '0;
            r_csum        <= '0;
            r_lane        <= '0;
            r_lanes       <= '0;
            words_written <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            r_rdy_en   <= 1'b1;
            bus.mem_we <= 1'b0;
            case (r_state)
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= bus.in_data;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8]   <= bus.in_data;
                        r_csum        <= '0;
                        r_lane        <= '0;
                        words_written <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_csum <= r_csum + bus.in_data;
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_lanes[7:0]   <= bus.in_data;
                            2'd1: r_lanes[15:8]  <= bus.in_data;
                            2'd2: r_lanes[23:16] <= bus.in_data;
                            default: begin
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= words_written[ADDR_WIDTH-1:0];
                                bus.mem_wdata <= DATA_WIDTH'({bus.in_data, r_lanes});
                            end
                        endcase
                    end
                    // The write cycle blocks in_ready, so no byte races the count update.
                    if (bus.mem_we) begin
                        words_written <= w_ww_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// tb_imem_loader : directed and randomized frame checks against a frame-level model.
// Rev 1.0
// ============================================================================
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;
    logic [8:0] words_written;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    imem_loader #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (8),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .cpu_hold      (cpu_hold),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_written (words_written)
    );

    int tests = 0;
    int fails = 0;

    logic [39:0] got[$];      // observed writes {addr, data}
    logic [39:0] exp_wr[$];   // model writes
    logic [7:0]  fr[$];       // frame bytes
    logic [31:0] wq[$];       // frame payload words
    bit          exp_good;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            got.push_back({bus.mem_addr, bus.mem_wdata});
            chk("ready_low_in_write", 64'(bus.in_ready), 64'd0);
        end
    end

    // Frame model: header, little-endian words, mod-256 sum of payload bytes.
    task automatic build_frame(input bit good);
        logic [7:0]  cs;
        logic [15:0] n;
        logic [31:0] w;
        cs = 8'd0;
        n  = 16'(wq.size());
        fr.delete();
        exp_wr.delete();
        fr.push_back(8'hA5);
        fr.push_back(n[7:0]);
        fr.push_back(n[15:8]);
        for (int i = 0; i < wq.size(); i++) begin
            w = wq[i];
            for (int b = 0; b < 4; b++) begin
                fr.push_back(w[8*b +: 8]);
                cs = cs + w[8*b +: 8];
            end
            exp_wr.push_back({8'(i), w});
        end
        fr.push_back(good ? cs : cs + 8'd1);
        exp_good = good;
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n;
        logic r;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (1) begin
            r = bus.in_ready;
            @(negedge clk);
            if (r) break;
            n++;
            if (n > 20) begin
                tests++;
                fails++;
                $error("FAIL handshake: in_ready observed 0 expected 1 within 20 cycles");
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit gaps);
        for (int k = 0; k < fr.size(); k++) begin
            send_byte(fr[k]);
            if (k >= 3 && k < fr.size() - 1)
                chk($sformatf("we_latency_byte%0d", k), 64'(bus.mem_we), 64'(((k - 3) % 4) == 3));
            if (gaps && ($urandom % 4 == 0) && k < fr.size() - 1)
                idle($urandom_range(1, 3));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwrites"}, 64'(got.size()), 64'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size(); i++)
            if (i < got.size()) chk($sformatf("%s_wr%0d", tag, i), 64'(got[i]), 64'(exp_wr[i]));
        chk({tag, "_done"},  64'(load_done),     64'(exp_good));
        chk({tag, "_error"}, 64'(load_error),    64'(!exp_good));
        chk({tag, "_hold"},  64'(cpu_hold),      64'(!exp_good));
        chk({tag, "_words"}, 64'(words_written), 64'(exp_wr.size()));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_hold"},  64'(cpu_hold),      64'd1);
        chk({tag, "_we"},    64'(bus.mem_we),    64'd0);
        chk({tag, "_ready"}, 64'(bus.in_ready),  64'd0);
        chk({tag, "_done"},  64'(load_done),     64'd0);
        chk({tag, "_error"}, 64'(load_error),    64'd0);
        chk({tag, "_words"}, 64'(words_written), 64'd0);
        chk({tag, "_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        logic [7:0] junk;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset, then idle-state discards
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 64'(bus.in_ready), 64'd1);
        got.delete();
        send_byte(8'h00);
        send_byte(8'h13);
        idle(2);
        chk("idle_discard_done",   64'(load_done),  64'd0);
        chk("idle_discard_error",  64'(load_error), 64'd0);
        chk("idle_discard_hold",   64'(cpu_hold),   64'd1);
        chk("idle_discard_writes", 64'(got.size()), 64'd0);

        // Two-word good frame
        wq.delete();
        wq.push_back(32'h0000_0013);
        wq.push_back(32'h0010_0093);
        build_frame(1'b1);
        got.delete();
        send_frame(1'b0);
        check_frame("two_word_good");

        // Same frame with a corrupted checksum, then an empty frame
        build_frame(1'b0);
        got.delete();
        send_frame(1'b0);
        check_frame("bad_csum");
        wq.delete();
        build_frame(1'b1);
        got.delete();
        send_frame(1'b0);
        check_frame("empty_frame");

        // Oversize length (257 words)
        got.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        bus.in_valid = 1'b0;
        chk("oversize_error", 64'(load_error), 64'd1);
        chk("oversize_hold",  64'(cpu_hold),   64'd1);
        idle(3);
        chk("oversize_writes", 64'(got.size()), 64'd0);

        // Reset mid-frame after the sixth byte, then a full reload
        wq.delete();
        wq.push_back(32'h0000_0013);
        wq.push_back(32'h0010_0093);
        build_frame(1'b1);
        got.delete();
        for (int k = 0; k < 6; k++) send_byte(fr[k]);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        chk("mid_reset_writes", 64'(got.size()), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        send_frame(1'b0);
        check_frame("reload");

        // Full-capacity frame
        rand_words(256);
        build_frame(1'b1);
        got.delete();
        send_frame(1'b0);
        check_frame("full_capacity");

        // Randomized frames with leading junk and valid gaps
        for (int t = 0; t < 12; t++) begin
            rand_words($urandom_range(0, 6));
            build_frame($urandom % 4 != 0);
            got.delete();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h00;
                send_byte(junk);
            end
            send_frame(1'b1);
            check_frame($sformatf("rand%0d", t));
        end

        // Mid-frame stall
        send_byte(8'hA5);
        send_byte(8'h02);
        bus.in_valid = 1'b0;
`ifdef IMEM_LOADER_TIMEOUT_EN
        repeat (9) @(negedge clk);
        chk("timeout_not_yet", 64'(load_error), 64'd0);
        @(negedge clk);
        chk("timeout_error", 64'(load_error), 64'd1);
        chk("timeout_hold",  64'(cpu_hold),   64'd1);
`else
        repeat (100) @(negedge clk);
        chk("stall_no_error", 64'(load_error), 64'd0);
        chk("stall_no_done",  64'(load_done),  64'd0);
        chk("stall_hold",     64'(cpu_hold),   64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
